// File: rtl/axi_mux_pkg.sv
// axi_mux shared types: AXI4 channel bundles and bus widths.
// Imported by axi_mux and the testbench.
package axi_mux_pkg;

  localparam int ID_W   = 2;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
  } axi_ax_t;

  typedef struct packed {
    logic [DATA_W-1:0]   data;
    logic [DATA_W/8-1:0] strb;
    logic                last;
  } axi_w_t;

  typedef struct packed {
    logic [ID_W-1:0] id;
    logic [1:0]      resp;
  } axi_b_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
    logic              last;
  } axi_r_t;

  typedef struct packed {
    axi_ax_t aw;
    logic    awvalid;
    axi_w_t  w;
    logic    wvalid;
    logic    bready;
    axi_ax_t ar;
    logic    arvalid;
    logic    rready;
  } axi_mosi_t;

  typedef struct packed {
    logic   awready;
    logic   wready;
    axi_b_t b;
    logic   bvalid;
    logic   arready;
    axi_r_t r;
    logic   rvalid;
  } axi_miso_t;

endpackage

// File: rtl/axi_rr_arbiter.sv
// Round-robin arbiter with offer lock: a granted-but-unaccepted
// request keeps the grant until advance_i.
module axi_rr_arbiter #(
  parameter int N = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [N-1:0]         req_i,
  input  logic                 hold_i,
  input  logic                 advance_i,
  output logic [$clog2(N)-1:0] gnt_o,
  output logic                 valid_o
);

  localparam int IW = $clog2(N);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] lock_idx_q, lock_idx_d;
  logic          lock_q, lock_d;
  logic [IW-1:0] rr_idx, cand;
  logic          rr_vld;

  // Scan from the far end so the nearest index after ptr wins last.
  always_comb begin
    rr_idx = '0;
    rr_vld = 1'b0;
    cand   = '0;
    for (int i = N; i >= 1; i--) begin
      cand = IW'((int'(ptr_q) + i) % N);
      if (req_i[cand]) begin
        rr_idx = cand;
        rr_vld = 1'b1;
      end
    end
  end

  assign gnt_o   = lock_q ? lock_idx_q : rr_idx;
  assign valid_o = lock_q ? req_i[lock_idx_q] : rr_vld;

  always_comb begin
    ptr_d      = ptr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (advance_i) begin
      ptr_d  = gnt_o;
      lock_d = 1'b0;
    end else if (hold_i) begin
      lock_d     = 1'b1;
      lock_idx_d = gnt_o;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q      <= IW'(N - 1);
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end

endmodule

// File: rtl/axi_mux.sv
// AXI4 N-to-1 mux: round-robin AW/AR, burst-locked W, ID-routed B/R.
// AXI_MUX_PMU_EN adds per-input saturating grant counters.
module axi_mux
  import axi_mux_pkg::*;
#(
  parameter int INPUT_NUM = 2,
  parameter int ID_ROUTING [2**ID_W] = '{0, 0, 0, 0}
) (
  input  logic      ACLK,
  input  logic      ARESETn,
  input  axi_mosi_t s_axi_i [INPUT_NUM],
  output axi_miso_t s_axi_o [INPUT_NUM],
  output axi_mosi_t m_axi_o,
`ifdef AXI_MUX_PMU_EN
  output logic [INPUT_NUM-1:0][31:0] pmu_grant_cnt_o,
`endif
  input  axi_miso_t m_axi_i
);

  localparam int IW = $clog2(INPUT_NUM);
  localparam logic [0:0] W_IDLE = 1'b0;
  localparam logic [0:0] W_DATA = 1'b1;

  logic [0:0]           w_state_q, w_state_d;
  logic [IW-1:0]        w_sel_q, w_sel_d;
  logic [INPUT_NUM-1:0] aw_req, ar_req;
  logic [IW-1:0]        aw_gnt, ar_gnt;
  logic                 aw_vld, ar_vld;
  logic                 w_idle, m_awvalid;
  logic                 aw_hs, ar_hs, w_hs;
  logic                 b_ok, r_ok;
  logic [IW-1:0]        b_idx, r_idx;

  always_comb begin
    aw_req = '0;
    ar_req = '0;
    for (int k = 0; k < INPUT_NUM; k++) begin
      aw_req[k] = s_axi_i[k].awvalid;
      ar_req[k] = s_axi_i[k].arvalid;
    end
  end

  assign w_idle    = w_state_q == W_IDLE;
  assign m_awvalid = aw_vld & w_idle;
  assign aw_hs     = m_awvalid & m_axi_i.awready;
  assign ar_hs     = ar_vld & m_axi_i.arready;
  assign w_hs      = ~w_idle & s_axi_i[w_sel_q].wvalid
                   & m_axi_i.wready;

  assign b_ok  = ID_ROUTING[m_axi_i.b.id] < INPUT_NUM;
  assign r_ok  = ID_ROUTING[m_axi_i.r.id] < INPUT_NUM;
  assign b_idx = IW'(ID_ROUTING[m_axi_i.b.id]);
  assign r_idx = IW'(ID_ROUTING[m_axi_i.r.id]);

  axi_rr_arbiter #(.N(INPUT_NUM)) u_aw_arb (
    .clk_i    (ACLK),
    .rst_ni   (ARESETn),
    .req_i    (aw_req),
    .hold_i   (m_awvalid & ~m_axi_i.awready),
    .advance_i(aw_hs),
    .gnt_o    (aw_gnt),
    .valid_o  (aw_vld)
  );

  axi_rr_arbiter #(.N(INPUT_NUM)) u_ar_arb (
    .clk_i    (ACLK),
    .rst_ni   (ARESETn),
    .req_i    (ar_req),
    .hold_i   (ar_vld & ~m_axi_i.arready),
    .advance_i(ar_hs),
    .gnt_o    (ar_gnt),
    .valid_o  (ar_vld)
  );

  // Every VALID/READY is forced low while reset is asserted.
  always_comb begin
    m_axi_o = '0;
    for (int k = 0; k < INPUT_NUM; k++) begin
      s_axi_o[k]   = '0;
      s_axi_o[k].b = m_axi_i.b;
      s_axi_o[k].r = m_axi_i.r;
    end
    if (ARESETn) begin
      if (m_awvalid) begin
        m_axi_o.aw              = s_axi_i[aw_gnt].aw;
        m_axi_o.awvalid         = 1'b1;
        s_axi_o[aw_gnt].awready = m_axi_i.awready;
      end
      if (!w_idle) begin
        m_axi_o.w               = s_axi_i[w_sel_q].w;
        m_axi_o.wvalid          = s_axi_i[w_sel_q].wvalid;
        s_axi_o[w_sel_q].wready = m_axi_i.wready;
      end
      if (ar_vld) begin
        m_axi_o.ar              = s_axi_i[ar_gnt].ar;
        m_axi_o.arvalid         = 1'b1;
        s_axi_o[ar_gnt].arready = m_axi_i.arready;
      end
      if (b_ok) begin
        s_axi_o[b_idx].bvalid = m_axi_i.bvalid;
        m_axi_o.bready        = s_axi_i[b_idx].bready;
      end else begin
        m_axi_o.bready = 1'b1;
      end
      if (r_ok) begin
        s_axi_o[r_idx].rvalid = m_axi_i.rvalid;
        m_axi_o.rready        = s_axi_i[r_idx].rready;
      end else begin
        m_axi_o.rready = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_d = w_state_q;
    w_sel_d   = w_sel_q;
    unique case (1'b1)
      w_idle: begin
        if (aw_hs) begin
          w_state_d = W_DATA;
          w_sel_d   = aw_gnt;
        end
      end
      !w_idle: begin
        if (w_hs && s_axi_i[w_sel_q].w.last) w_state_d = W_IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_state_q <= W_IDLE;
      w_sel_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      w_sel_q   <= w_sel_d;
    end
  end

`ifdef AXI_MUX_PMU_EN
  logic [INPUT_NUM-1:0][31:0] cnt_q, cnt_d;
  logic [INPUT_NUM-1:0][32:0] cnt_sum;

  always_comb begin
    cnt_d   = cnt_q;
    cnt_sum = '0;
    for (int k = 0; k < INPUT_NUM; k++) begin
      cnt_sum[k] = {1'b0, cnt_q[k]}
                 + 33'(aw_hs && aw_gnt == IW'(k))
                 + 33'(ar_hs && ar_gnt == IW'(k));
      cnt_d[k]   = cnt_sum[k][32] ? '1 : cnt_sum[k][31:0];
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign pmu_grant_cnt_o = cnt_q;
`endif

endmodule

// File: tb/tb_axi_mux.sv
// Self-checking bench for axi_mux (3 inputs, ID map 0->0 1->1 2->1 3->5).
// Drives at posedge+1, samples at posedge+2.
module tb_axi_mux;
  import axi_mux_pkg::*;

  localparam int NI = 3;
  localparam int ROUTE [4] = '{0, 1, 1, 5};

  logic      clk = 1'b0;
  logic      rst_n = 1'b0;
  axi_mosi_t s_in [NI];
  axi_miso_t s_out [NI];
  axi_mosi_t m_out;
  axi_miso_t m_in;
`ifdef AXI_MUX_PMU_EN
  logic [NI-1:0][31:0] pmu;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  int aw_ptr = NI - 1;
  int ar_ptr = NI - 1;

  axi_mux #(.INPUT_NUM(NI), .ID_ROUTING(ROUTE)) dut (
    .ACLK   (clk),
    .ARESETn(rst_n),
    .s_axi_i(s_in),
    .s_axi_o(s_out),
    .m_axi_o(m_out),
`ifdef AXI_MUX_PMU_EN
    .pmu_grant_cnt_o(pmu),
`endif
    .m_axi_i(m_in)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, summary not printed");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    for (int k = 0; k < NI; k++) s_in[k] = '0;
    m_in = '0;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    aw_ptr = NI - 1;
    ar_ptr = NI - 1;
  endtask

  // Reference round-robin: first requester after ptr, wrapping.
  function automatic int rr(int ptr, int req);
    for (int i = 1; i <= NI; i++) begin
      if (((req >> ((ptr + i) % NI)) & 1) != 0) return (ptr + i) % NI;
    end
    return -1;
  endfunction

  function automatic int granted();
    int g = -1;
    for (int k = 0; k < NI; k++)
      if (s_out[k].awready) g = (g == -1) ? k : -2;
    return g;
  endfunction

  function automatic logic any_vr();
    logic a = m_out.awvalid | m_out.wvalid | m_out.arvalid
            | m_out.bready | m_out.rready;
    for (int k = 0; k < NI; k++)
      a |= s_out[k].awready | s_out[k].wready | s_out[k].arready
         | s_out[k].bvalid | s_out[k].rvalid;
    return a;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    for (int k = 0; k < NI; k++) begin
      s_in[k].awvalid = 1'b1;
      s_in[k].wvalid  = 1'b1;
      s_in[k].arvalid = 1'b1;
      s_in[k].bready  = 1'b1;
      s_in[k].rready  = 1'b1;
    end
    m_in.awready = 1'b1;
    m_in.wready  = 1'b1;
    m_in.arready = 1'b1;
    m_in.bvalid  = 1'b1;
    m_in.rvalid  = 1'b1;
    #1;
    n_cmp++;
    if (any_vr() !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_vr: some valid/ready=%b, want 0", any_vr());
    end
    apply_reset();
`ifdef AXI_MUX_PMU_EN
    #1;
    n_cmp++;
    if (pmu !== '0) begin
      n_bad++;
      $display("FAIL pmu_reset: got %h want 0", pmu);
    end
`endif
  endtask

  task automatic test_single_write();
    logic [31:0] addr, d [4], ram [4];
    apply_reset();
    addr = $urandom() & 32'hFFFF_FFF0;
    for (int b = 0; b < 4; b++) d[b] = $urandom();
    s_in[1].awvalid = 1'b1;
    s_in[1].aw.id   = 2'd2;
    s_in[1].aw.len  = 8'd3;
    s_in[1].aw.addr = addr;
    m_in.awready    = 1'b1;
    #1;
    n_cmp++;
    if (m_out.awvalid !== 1'b1 || m_out.aw.addr !== addr
        || m_out.aw.id !== 2'd2 || granted() !== 1) begin
      n_bad++;
      $display("FAIL sw_aw: v=%b addr=%h id=%0d gnt=%0d want 1 %h 2 1",
               m_out.awvalid, m_out.aw.addr, m_out.aw.id, granted(), addr);
    end
    step();
    aw_ptr = 1;
    s_in[1].awvalid = 1'b0;
    m_in.wready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      s_in[1].wvalid = 1'b1;
      s_in[1].w.data = d[b];
      s_in[1].w.last = (b == 3);
      #1;
      ram[b] = m_out.w.data;
      n_cmp++;
      if (m_out.wvalid !== 1'b1 || m_out.w.data !== d[b]
          || m_out.w.last !== (b == 3) || s_out[1].wready !== 1'b1) begin
        n_bad++;
        $display("FAIL sw_w%0d: v=%b data=%h last=%b rdy=%b want 1 %h %b 1",
                 b, m_out.wvalid, m_out.w.data, m_out.w.last,
                 s_out[1].wready, d[b], b == 3);
      end
      step();
    end
    s_in[1].wvalid = 1'b0;
    m_in.wready    = 1'b0;
    m_in.bvalid    = 1'b1;
    m_in.b.id      = 2'd2;
    s_in[1].bready = 1'b0;
    #1;
    n_cmp++;
    if (s_out[1].bvalid !== 1'b1 || s_out[0].bvalid !== 1'b0
        || s_out[2].bvalid !== 1'b0 || m_out.bready !== 1'b0) begin
      n_bad++;
      $display("FAIL sw_b: bv=%b%b%b bready=%b want 010 0",
               s_out[2].bvalid, s_out[1].bvalid, s_out[0].bvalid,
               m_out.bready);
    end
    s_in[1].bready = 1'b1;
    #1;
    n_cmp++;
    if (m_out.bready !== 1'b1) begin
      n_bad++;
      $display("FAIL sw_bready: got %b want 1", m_out.bready);
    end
    step();
    m_in.bvalid     = 1'b0;
    s_in[1].arvalid = 1'b1;
    s_in[1].ar.id   = 2'd2;
    s_in[1].ar.addr = addr;
    s_in[1].ar.len  = 8'd3;
    m_in.arready    = 1'b1;
    #1;
    n_cmp++;
    if (m_out.arvalid !== 1'b1 || m_out.ar.addr !== addr
        || s_out[1].arready !== 1'b1 || s_out[0].arready !== 1'b0) begin
      n_bad++;
      $display("FAIL sw_ar: v=%b addr=%h rdy1=%b rdy0=%b want 1 %h 1 0",
               m_out.arvalid, m_out.ar.addr, s_out[1].arready,
               s_out[0].arready, addr);
    end
    step();
    ar_ptr = 1;
    s_in[1].arvalid = 1'b0;
    m_in.arready    = 1'b0;
    s_in[1].rready  = 1'b1;
    for (int b = 0; b < 4; b++) begin
      m_in.rvalid = 1'b1;
      m_in.r.id   = 2'd2;
      m_in.r.data = ram[b];
      m_in.r.last = (b == 3);
      #1;
      n_cmp++;
      if (s_out[1].rvalid !== 1'b1 || s_out[1].r.data !== d[b]
          || s_out[0].rvalid !== 1'b0 || s_out[2].rvalid !== 1'b0) begin
        n_bad++;
        $display("FAIL sw_r%0d: v1=%b data=%h v0=%b v2=%b want 1 %h 0 0",
                 b, s_out[1].rvalid, s_out[1].r.data, s_out[0].rvalid,
                 s_out[2].rvalid, d[b]);
      end
      step();
    end
    clear_inputs();
  endtask

  task automatic test_contention();
    int exp;
    logic [31:0] wd;
    apply_reset();
    for (int k = 0; k < NI; k++) begin
      s_in[k].awvalid = 1'b1;
      s_in[k].aw.id   = 2'(k);
    end
    m_in.awready = 1'b1;
    m_in.wready  = 1'b1;
    for (int g = 0; g < 4; g++) begin
      #1;
      exp = rr(aw_ptr, 7);
      n_cmp++;
      if (granted() !== exp || exp !== g % NI) begin
        n_bad++;
        $display("FAIL cont_grant%0d: got %0d want %0d", g, granted(), g % NI);
      end
      step();
      aw_ptr = exp;
      wd = $urandom();
      s_in[exp].wvalid = 1'b1;
      s_in[exp].w.last = 1'b1;
      s_in[exp].w.data = wd;
      #1;
      n_cmp++;
      if (m_out.awvalid !== 1'b0 || s_out[exp].wready !== 1'b1
          || m_out.w.data !== wd) begin
        n_bad++;
        $display("FAIL cont_w%0d: awv=%b wrdy=%b data=%h want 0 1 %h",
                 g, m_out.awvalid, s_out[exp].wready, m_out.w.data, wd);
      end
      step();
      s_in[exp].wvalid = 1'b0;
    end
    clear_inputs();
  endtask

  task automatic test_random_aw();
    int req, exp, stall;
    for (int k = 0; k < NI; k++) s_in[k].aw.id = 2'(k);
    m_in.wready = 1'b1;
    for (int n = 0; n < 12; n++) begin
      req = $urandom_range(1, 7);
      for (int k = 0; k < NI; k++) s_in[k].awvalid = ((req >> k) & 1) != 0;
      exp = rr(aw_ptr, req);
      stall = $urandom_range(0, 2);
      m_in.awready = 1'b0;
      repeat (stall) begin
        #1;
        n_cmp++;
        if (m_out.awvalid !== 1'b1 || m_out.aw.id !== 2'(exp)) begin
          n_bad++;
          $display("FAIL rnd_hold%0d: v=%b id=%0d want 1 %0d",
                   n, m_out.awvalid, m_out.aw.id, exp);
        end
        step();
        req = $urandom_range(0, 7) | (1 << exp);
        for (int k = 0; k < NI; k++) s_in[k].awvalid = ((req >> k) & 1) != 0;
      end
      m_in.awready = 1'b1;
      #1;
      n_cmp++;
      if (granted() !== exp) begin
        n_bad++;
        $display("FAIL rnd_grant%0d: got %0d want %0d", n, granted(), exp);
      end
      step();
      aw_ptr = exp;
      for (int k = 0; k < NI; k++) s_in[k].awvalid = 1'b0;
      s_in[exp].wvalid = 1'b1;
      s_in[exp].w.last = 1'b1;
      step();
      s_in[exp].wvalid = 1'b0;
    end
    clear_inputs();
  endtask

  task automatic test_w_lock();
    logic [31:0] wd;
    s_in[2].awvalid = 1'b1;
    s_in[2].aw.len  = 8'd7;
    m_in.awready    = 1'b1;
    m_in.wready     = 1'b1;
    s_in[0].wvalid  = 1'b1;
    s_in[0].w.data  = 32'hDEAD_0000;
    s_in[0].w.last  = 1'b1;
    #1;
    n_cmp++;
    if (granted() !== 2 || m_out.wvalid !== 1'b0) begin
      n_bad++;
      $display("FAIL wl_aw: gnt=%0d wv=%b want 2 0", granted(), m_out.wvalid);
    end
    step();
    aw_ptr = 2;
    s_in[2].awvalid = 1'b0;
    s_in[0].awvalid = 1'b1;
    for (int b = 0; b < 8; b++) begin
      wd = $urandom();
      s_in[2].wvalid = 1'b1;
      s_in[2].w.data = wd;
      s_in[2].w.last = (b == 7);
      #1;
      n_cmp++;
      if (s_out[0].wready !== 1'b0 || s_out[2].wready !== 1'b1
          || m_out.w.data !== wd || m_out.awvalid !== 1'b0
          || s_out[0].awready !== 1'b0) begin
        n_bad++;
        $display("FAIL wl_beat%0d: r0=%b r2=%b data=%h awv=%b want 0 1 %h 0",
                 b, s_out[0].wready, s_out[2].wready, m_out.w.data,
                 m_out.awvalid, wd);
      end
      step();
    end
    s_in[2].wvalid = 1'b0;
    #1;
    n_cmp++;
    if (granted() !== rr(aw_ptr, 1)) begin
      n_bad++;
      $display("FAIL wl_next: gnt=%0d want %0d", granted(), rr(aw_ptr, 1));
    end
    step();
    aw_ptr = 0;
    s_in[0].awvalid = 1'b0;
    #1;
    n_cmp++;
    if (s_out[0].wready !== 1'b1 || m_out.w.data !== 32'hDEAD_0000) begin
      n_bad++;
      $display("FAIL wl_w0: rdy=%b data=%h want 1 dead0000",
               s_out[0].wready, m_out.w.data);
    end
    step();
    clear_inputs();
  endtask

  task automatic test_read_interleave();
    int req, exp, id, owner, rmask, exp_v, obs_v, exp_rdy;
    logic [31:0] rd;
    req = 3;
    s_in[0].arvalid = 1'b1;
    s_in[0].ar.id   = 2'd0;
    s_in[1].arvalid = 1'b1;
    s_in[1].ar.id   = 2'd1;
    m_in.arready    = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      exp = rr(ar_ptr, req);
      n_cmp++;
      if (s_out[exp].arready !== 1'b1 || m_out.ar.id !== 2'(exp)) begin
        n_bad++;
        $display("FAIL ri_ar%0d: rdy=%b id=%0d want 1 %0d",
                 c, s_out[exp].arready, m_out.ar.id, exp);
      end
      step();
      ar_ptr = exp;
      s_in[exp].arvalid = 1'b0;
      req &= ~(1 << exp);
    end
    m_in.arready = 1'b0;
    for (int n = 0; n < 16; n++) begin
      id = $urandom_range(0, 3);
      owner = ROUTE[id];
      rmask = $urandom_range(0, 7);
      rd = $urandom();
      for (int k = 0; k < NI; k++) s_in[k].rready = ((rmask >> k) & 1) != 0;
      m_in.rvalid = 1'b1;
      m_in.r.id   = 2'(id);
      m_in.r.data = rd;
      exp_v   = (owner < NI) ? (1 << owner) : 0;
      exp_rdy = (owner < NI) ? ((rmask >> owner) & 1) : 1;
      #1;
      obs_v = 0;
      for (int k = 0; k < NI; k++) if (s_out[k].rvalid) obs_v |= (1 << k);
      n_cmp++;
      if (obs_v !== exp_v || int'(m_out.rready) !== exp_rdy
          || (owner < NI && s_out[owner].r.data !== rd)) begin
        n_bad++;
        $display("FAIL ri_r%0d id=%0d: vmask=%0d rready=%b want %0d %0d",
                 n, id, obs_v, m_out.rready, exp_v, exp_rdy);
      end
      step();
    end
    clear_inputs();
  endtask

  task automatic test_unmapped();
    int obs_v;
    m_in.bvalid = 1'b1;
    m_in.b.id   = 2'd3;
    for (int k = 0; k < NI; k++) s_in[k].bready = 1'b0;
    #1;
    obs_v = 0;
    for (int k = 0; k < NI; k++) if (s_out[k].bvalid) obs_v |= (1 << k);
    n_cmp++;
    if (m_out.bready !== 1'b1 || obs_v !== 0) begin
      n_bad++;
      $display("FAIL unmapped_b: bready=%b vmask=%0d want 1 0",
               m_out.bready, obs_v);
    end
    step();
    clear_inputs();
  endtask

  task automatic test_reset_mid_burst();
    s_in[1].awvalid = 1'b1;
    s_in[1].aw.len  = 8'd3;
    m_in.awready    = 1'b1;
    m_in.wready     = 1'b1;
    #1;
    n_cmp++;
    if (granted() !== 1) begin
      n_bad++;
      $display("FAIL rm_aw: gnt=%0d want 1", granted());
    end
    step();
    s_in[1].awvalid = 1'b0;
    s_in[1].wvalid  = 1'b1;
    repeat (2) step();
    for (int k = 0; k < NI; k++) s_in[k].awvalid = 1'b1;
    m_in.bvalid = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (any_vr() !== 1'b0) begin
      n_bad++;
      $display("FAIL rm_async: some valid/ready=%b want 0", any_vr());
    end
    m_in.bvalid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    aw_ptr = NI - 1;
    ar_ptr = NI - 1;
    s_in[0].arvalid = 1'b1;
    m_in.arready    = 1'b1;
    #1;
    n_cmp++;
    if (granted() !== 0 || m_out.wvalid !== 1'b0) begin
      n_bad++;
      $display("FAIL rm_prio: gnt=%0d wv=%b want 0 0",
               granted(), m_out.wvalid);
    end
`ifdef AXI_MUX_PMU_EN
    n_cmp++;
    if (pmu !== '0) begin
      n_bad++;
      $display("FAIL pmu_clr: got %h want 0", pmu);
    end
`endif
    step();
`ifdef AXI_MUX_PMU_EN
    n_cmp++;
    if (pmu[0] !== 32'd2 || pmu[1] !== 32'd0) begin
      n_bad++;
      $display("FAIL pmu_cnt: p0=%0d p1=%0d want 2 0", pmu[0], pmu[1]);
    end
`endif
    clear_inputs();
    step();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_write();
    test_contention();
    test_random_aw();
    test_w_lock();
    test_read_interleave();
    test_unmapped();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
